// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/PC-load controller for the in-order RV32I pipeline
module pipe_hazard_ctrl #(
    parameter int NUM_REGS    = 5,
    parameter int REG_ADDR_W  = 5,
    parameter int RESOLVE_IDX = 2,
    parameter int LU_BUBBLES  = 1,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_late_wr,
    input  logic                  redirect_valid,
    input  logic                  imem_req,
    input  logic                  imem_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    input  logic                  perf_clr,
    output logic [NUM_REGS-1:0]   stall,
    output logic [NUM_REGS-1:0]   flush,
    output logic                  pc_load,
    output logic                  redirect_pending,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LU_WAIT = 1'b1;

    localparam logic [NUM_REGS-1:0] ALL_STALL   = '1;
    localparam logic [NUM_REGS-1:0] FRONT_STALL = NUM_REGS'(3);
    localparam logic [NUM_REGS-1:0] FRONT_FLUSH = NUM_REGS'(4);
    // Bits 1..RESOLVE_IDX: every younger register holding wrong-path work.
    localparam logic [NUM_REGS-1:0] REDIR_FLUSH = NUM_REGS'((1 << (RESOLVE_IDX + 1)) - 2);
    localparam logic [1:0]          LU_LOAD     = 2'(LU_BUBBLES - 1);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [1:0] lu_cnt;
    logic [1:0] lu_cnt_nxt;
    logic       pending_nxt;

    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic dstall;
    logic istall;
    logic redir_req;

    assign rs1_hit   = id_rs1_used && (id_rs1 == ex_rd) && (id_rs1 != '0);
    assign rs2_hit   = id_rs2_used && (id_rs2 == ex_rd) && (id_rs2 != '0);
    assign hazard    = ex_late_wr && (rs1_hit || rs2_hit);
    assign dstall    = dmem_req && !dmem_resp;
    assign istall    = imem_req && !imem_resp;
    assign redir_req = redirect_valid || redirect_pending;

    always_comb begin
        stall       = '0;
        flush       = '0;
        pc_load     = 1'b1;
        state_nxt   = state;
        lu_cnt_nxt  = lu_cnt;
        pending_nxt = redirect_pending;

        if (rst) begin
            pc_load = 1'b0;
        end else if (dstall) begin
            // Whole pipe frozen; a redirect seen now is remembered for release.
            stall       = ALL_STALL;
            pc_load     = 1'b0;
            pending_nxt = redirect_pending || redirect_valid;
        end else if (redir_req) begin
            flush       = REDIR_FLUSH;
            pc_load     = !istall;
            pending_nxt = istall;
            state_nxt   = ST_IDLE;
            lu_cnt_nxt  = 2'd0;
        end else if (state == ST_LU_WAIT) begin
            // The producer has already left EX, so the live hazard is ignored here.
            stall      = FRONT_STALL;
            flush      = FRONT_FLUSH;
            pc_load    = 1'b0;
            lu_cnt_nxt = lu_cnt - 2'd1;
            if (lu_cnt == 2'd1) begin
                state_nxt = ST_IDLE;
            end
        end else if (hazard) begin
            stall   = FRONT_STALL;
            flush   = FRONT_FLUSH;
            pc_load = 1'b0;
            if (LU_BUBBLES > 1) begin
                state_nxt  = ST_LU_WAIT;
                lu_cnt_nxt = LU_LOAD;
            end
        end else if (istall) begin
            stall   = FRONT_STALL;
            flush   = FRONT_FLUSH;
            pc_load = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            lu_cnt           <= 2'd0;
            redirect_pending <= 1'b0;
        end else begin
            state            <= state_nxt;
            lu_cnt           <= lu_cnt_nxt;
            redirect_pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (stall[0]) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed checks of pipe_hazard_ctrl against a bubble-count model
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_late_wr, redirect_valid;
    logic       imem_req, imem_resp, dmem_req, dmem_resp, perf_clr;

    logic [4:0]  stall_a, flush_a, stall_b, flush_b;
    logic        pc_load_a, pc_load_b, pend_a, pend_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    logic [43:0] act_a, exp_a;
    logic [15:0] act_b, exp_b;

    int vectors = 0;
    int miscompares = 0;

    int     m_left [2];
    bit     m_pend [2];
    longint m_cnt  [2];
    int     n_left [2];
    bit     n_pend [2];
    longint n_cnt  [2];

    always #5 clk = ~clk;

    assign act_a = {stall_a, flush_a, pc_load_a, pend_a, cnt_a};
    assign act_b = {stall_b, flush_b, pc_load_b, pend_b, cnt_b};

    pipe_hazard_ctrl #(.NUM_REGS(5), .REG_ADDR_W(5), .RESOLVE_IDX(2), .LU_BUBBLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_late_wr(ex_late_wr),
        .redirect_valid(redirect_valid), .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .perf_clr(perf_clr),
        .stall(stall_a), .flush(flush_a), .pc_load(pc_load_a),
        .redirect_pending(pend_a), .stall_cycles(cnt_a)
    );

    pipe_hazard_ctrl #(.NUM_REGS(5), .REG_ADDR_W(5), .RESOLVE_IDX(2), .LU_BUBBLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_late_wr(ex_late_wr),
        .redirect_valid(redirect_valid), .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .perf_clr(perf_clr),
        .stall(stall_b), .flush(flush_b), .pc_load(pc_load_b),
        .redirect_pending(pend_b), .stall_cycles(cnt_b)
    );

    // Model: remaining bubbles and a pending flag per instance, outputs from the priority list.
    task automatic predict();
        bit         ds, is, hz;
        logic [4:0] e_stall, e_flush;
        bit         e_pl;
        int         lub;
        longint     mask;
        ds = dmem_req && !dmem_resp;
        is = imem_req && !imem_resp;
        hz = ex_late_wr && ((id_rs1_used && id_rs1 == ex_rd && id_rs1 != 0) ||
                            (id_rs2_used && id_rs2 == ex_rd && id_rs2 != 0));
        for (int d = 0; d < 2; d++) begin
            lub  = (d == 0) ? 1 : 3;
            mask = (d == 0) ? 64'hFFFF_FFFF : 64'hF;
            if (rst) begin
                m_left[d] = 0; m_pend[d] = 0; m_cnt[d] = 0;
            end
            n_left[d] = m_left[d];
            n_pend[d] = m_pend[d];
            if (rst) begin
                e_stall = 0; e_flush = 0; e_pl = 0;
            end else if (ds) begin
                e_stall = 5'b11111; e_flush = 0; e_pl = 0;
                n_pend[d] = m_pend[d] | redirect_valid;
            end else if (redirect_valid || m_pend[d]) begin
                e_stall = 0; e_flush = 5'b00110; e_pl = !is;
                n_pend[d] = is; n_left[d] = 0;
            end else if (m_left[d] > 0 || hz) begin
                e_stall = 5'b00011; e_flush = 5'b00100; e_pl = 0;
                n_left[d] = (m_left[d] > 0) ? m_left[d] - 1 : lub - 1;
            end else if (is) begin
                e_stall = 5'b00011; e_flush = 5'b00100; e_pl = 0;
            end else begin
                e_stall = 0; e_flush = 0; e_pl = 1;
            end
            n_cnt[d] = perf_clr ? 0 : ((m_cnt[d] + longint'(e_stall[0])) & mask);
            if (rst) begin
                n_left[d] = 0; n_pend[d] = 0; n_cnt[d] = 0;
            end
            if (d == 0) exp_a = {e_stall, e_flush, e_pl, m_pend[d], 32'(m_cnt[d])};
            else        exp_b = {e_stall, e_flush, e_pl, m_pend[d], 4'(m_cnt[d])};
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_left[d] = n_left[d]; m_pend[d] = n_pend[d]; m_cnt[d] = n_cnt[d];
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_late_wr = 0; redirect_valid = 0; imem_req = 0; imem_resp = 0;
        dmem_req = 0; dmem_resp = 0; perf_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_rs1 = 5; ex_rd = 5; id_rs1_used = 1; ex_late_wr = 1;
            imem_req = 1'($urandom); dmem_req = 1'($urandom); redirect_valid = 1'($urandom);
            #2; predict();
            vectors++; if (act_a !== exp_a) begin miscompares++; $display("FAIL reset_a cyc=%0d got %h want %h", i, act_a, exp_a); end
            vectors++; if (act_b !== exp_b) begin miscompares++; $display("FAIL reset_b cyc=%0d got %h want %h", i, act_b, exp_b); end
            vectors++; if ({stall_a, flush_a, pc_load_a} !== 11'd0) begin miscompares++; $display("FAIL reset_outs got %h want 0", {stall_a, flush_a, pc_load_a}); end
            advance();
        end
        set_idle();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        set_idle();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin ex_rd = 5; ex_late_wr = 1; id_rs1 = 5; id_rs1_used = 1; end
            else set_idle();
            #2; predict();
            vectors++; if (act_a !== exp_a) begin miscompares++; $display("FAIL load_use_a cyc=%0d got %h want %h", i, act_a, exp_a); end
            vectors++; if (act_b !== exp_b) begin miscompares++; $display("FAIL load_use_b cyc=%0d got %h want %h", i, act_b, exp_b); end
            if (i == 0) begin
                vectors++;
                if ({stall_a, flush_a, pc_load_a} !== {5'b00011, 5'b00100, 1'b0}) begin
                    miscompares++; $display("FAIL lu1_bubble got %h want %h", {stall_a, flush_a, pc_load_a}, {5'b00011, 5'b00100, 1'b0});
                end
            end
            if (i == 1) begin
                vectors++;
                if ({stall_a, flush_a, pc_load_a} !== {10'd0, 1'b1}) begin
                    miscompares++; $display("FAIL lu1_release got %h want %h", {stall_a, flush_a, pc_load_a}, {10'd0, 1'b1});
                end
            end
            if (i <= 3) begin
                vectors++;
                if (stall_b[1:0] !== ((i < 3) ? 2'b11 : 2'b00)) begin
                    miscompares++; $display("FAIL lu3_stall cyc=%0d got %b want %b", i, stall_b[1:0], (i < 3) ? 2'b11 : 2'b00);
                end
            end
            advance();
        end
    endtask

    task automatic test_x0_unused();
        for (int i = 0; i < 2; i++) begin
            set_idle();
            ex_late_wr = 1;
            if (i == 0) begin id_rs1 = 0; ex_rd = 0; id_rs1_used = 1; end
            else begin id_rs2 = 7; ex_rd = 7; id_rs2_used = 0; id_rs1 = 3; id_rs1_used = 1; end
            #2; predict();
            vectors++; if (act_a !== exp_a) begin miscompares++; $display("FAIL x0_unused_a cyc=%0d got %h want %h", i, act_a, exp_a); end
            vectors++; if (act_b !== exp_b) begin miscompares++; $display("FAIL x0_unused_b cyc=%0d got %h want %h", i, act_b, exp_b); end
            vectors++; if ({stall_b, flush_b} !== 10'd0) begin miscompares++; $display("FAIL x0_unused_quiet got %h want 0", {stall_b, flush_b}); end
            advance();
        end
    endtask

    task automatic test_dmem_redirect();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            dmem_req = (i < 5);
            dmem_resp = (i == 4);
            redirect_valid = (i == 1);
            #2; predict();
            vectors++; if (act_a !== exp_a) begin miscompares++; $display("FAIL dmem_redir_a cyc=%0d got %h want %h", i, act_a, exp_a); end
            vectors++; if (act_b !== exp_b) begin miscompares++; $display("FAIL dmem_redir_b cyc=%0d got %h want %h", i, act_b, exp_b); end
            if (i < 4) begin
                vectors++;
                if ({stall_a, flush_a, pend_a} !== {5'b11111, 5'b0, (i >= 2) ? 1'b1 : 1'b0}) begin
                    miscompares++; $display("FAIL dmem_hold cyc=%0d got %h want %h", i, {stall_a, flush_a, pend_a}, {5'b11111, 5'b0, (i >= 2) ? 1'b1 : 1'b0});
                end
            end else if (i == 4) begin
                vectors++;
                if ({flush_a, pc_load_a} !== {5'b00110, 1'b1}) begin
                    miscompares++; $display("FAIL dmem_release got %h want %h", {flush_a, pc_load_a}, {5'b00110, 1'b1});
                end
            end else begin
                vectors++;
                if (pend_a !== 1'b0) begin miscompares++; $display("FAIL dmem_pend_clear got %b want 0", pend_a); end
            end
            advance();
        end
    endtask

    task automatic test_imem_redirect();
        for (int i = 0; i < 5; i++) begin
            set_idle();
            imem_req = (i < 4);
            imem_resp = (i == 3);
            redirect_valid = (i == 0);
            #2; predict();
            vectors++; if (act_a !== exp_a) begin miscompares++; $display("FAIL imem_redir_a cyc=%0d got %h want %h", i, act_a, exp_a); end
            vectors++; if (act_b !== exp_b) begin miscompares++; $display("FAIL imem_redir_b cyc=%0d got %h want %h", i, act_b, exp_b); end
            if (i < 3) begin
                vectors++;
                if ({flush_a[2:1], pc_load_a} !== 3'b110) begin
                    miscompares++; $display("FAIL imem_hold cyc=%0d got %b want 110", i, {flush_a[2:1], pc_load_a});
                end
            end else if (i == 3) begin
                vectors++;
                if ({flush_a[1], pc_load_a, pend_a} !== 3'b111) begin
                    miscompares++; $display("FAIL imem_release got %b want 111", {flush_a[1], pc_load_a, pend_a});
                end
            end else begin
                vectors++;
                if (pend_a !== 1'b0) begin miscompares++; $display("FAIL imem_pend_clear got %b want 0", pend_a); end
            end
            advance();
        end
    endtask

    task automatic test_counter();
        set_idle();
        perf_clr = 1;
        #2; predict(); advance();
        for (int i = 0; i < 31; i++) begin
            set_idle();
            imem_req = (i < 10 || i > 11);
            perf_clr = (i == 10);
            #2; predict();
            vectors++; if (act_a !== exp_a) begin miscompares++; $display("FAIL counter_a cyc=%0d got %h want %h", i, act_a, exp_a); end
            vectors++; if (act_b !== exp_b) begin miscompares++; $display("FAIL counter_b cyc=%0d got %h want %h", i, act_b, exp_b); end
            if (i == 10) begin
                vectors++; if (cnt_a !== 32'd10) begin miscompares++; $display("FAIL counter_ten got %0d want 10", cnt_a); end
            end
            if (i == 11) begin
                vectors++; if (cnt_a !== 32'd0) begin miscompares++; $display("FAIL counter_clr got %0d want 0", cnt_a); end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            if (i == 0) begin ex_rd = 9; ex_late_wr = 1; id_rs2 = 9; id_rs2_used = 1; end
            if (i >= 1) begin dmem_req = 1; redirect_valid = (i == 1); end
            #2; predict();
            vectors++; if (act_b !== exp_b) begin miscompares++; $display("FAIL reset_mid_b cyc=%0d got %h want %h", i, act_b, exp_b); end
            if (i < 2) advance();
        end
        rst = 1'b1;
        #1; predict();
        vectors++; if (act_a !== exp_a) begin miscompares++; $display("FAIL reset_mid_a got %h want %h", act_a, exp_a); end
        vectors++;
        if ({stall_b, flush_b, pc_load_b, pend_b, cnt_b} !== 16'd0) begin
            miscompares++; $display("FAIL reset_mid_async got %h want 0", {stall_b, flush_b, pc_load_b, pend_b, cnt_b});
        end
        advance();
        rst = 1'b0;
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 99) < 1);
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            ex_rd          = 5'($urandom_range(0, 3));
            id_rs1_used    = 1'($urandom);
            id_rs2_used    = 1'($urandom);
            ex_late_wr     = 1'($urandom);
            redirect_valid = ($urandom_range(0, 99) < 15);
            imem_req       = ($urandom_range(0, 99) < 40);
            imem_resp      = 1'($urandom);
            dmem_req       = ($urandom_range(0, 99) < 25);
            dmem_resp      = 1'($urandom);
            perf_clr       = ($urandom_range(0, 99) < 3);
            #2; predict();
            vectors++; if (act_a !== exp_a) begin miscompares++; $display("FAIL random_a cyc=%0d got %h want %h", i, act_a, exp_a); end
            vectors++; if (act_b !== exp_b) begin miscompares++; $display("FAIL random_b cyc=%0d got %h want %h", i, act_b, exp_b); end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        for (int d = 0; d < 2; d++) begin
            m_left[d] = 0; m_pend[d] = 0; m_cnt[d] = 0;
        end
        test_reset();
        test_load_use();
        test_x0_unused();
        test_dmem_redirect();
        test_imem_redirect();
        test_counter();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised stall/flush controller for the in-order RV32I pipeline; successor to the single-configuration hazard unit.
- Drives per-register stall and flush vectors plus the PC load enable.
- Adds a multi-cycle load-use bubble counter, redirects that survive memory stalls, and a stall-cycle performance counter.
- Sits beside the datapath; combinational inputs in, registered state inside.

Parameters:
- NUM_REGS, 5, number of pipeline registers; index 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB; legal range 4..8.
- REG_ADDR_W, 5, register-file address width.
- RESOLVE_IDX, 2, register holding the instruction that resolves branches/jumps; legal range 2..NUM_REGS-2.
- LU_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- id_rs1  in  REG_ADDR_W  rs1 of instruction in IF/ID.
- id_rs2  in  REG_ADDR_W  rs2 of instruction in IF/ID.
- id_rs1_used  in  1  decode uses rs1.
- id_rs2_used  in  1  decode uses rs2.
- ex_rd  in  REG_ADDR_W  rd of instruction in ID/EX.
- ex_late_wr  in  1  ID/EX instruction's result is not forwardable from EX (load, slt/sltu).
- redirect_valid  in  1  taken branch or jal/jalr resolved at RESOLVE_IDX.
- imem_req  in  1  fetch outstanding.
- imem_resp  in  1  fetch data valid.
- dmem_req  in  1  data read or write outstanding.
- dmem_resp  in  1  data access complete.
- perf_clr  in  1  synchronous clear of stall_cycles.
- stall  out  NUM_REGS  bit i=1: register i holds its value.
- flush  out  NUM_REGS  bit i=1: register i loads a bubble (NOP, control zeroed).
- pc_load  out  1  PC register accepts next/redirect value.
- redirect_pending  out  1  latched redirect awaiting release.
- stall_cycles  out  CNT_W  cycles with stall[0]=1 since reset/clear.

Behaviour:
- Reset (async, rst=1): state=IDLE, lu_cnt=0, redirect_pending=0, stall_cycles=0. While rst is asserted, stall=0, flush=0, pc_load=0.
- hazard = (id_rs1_used & id_rs1==ex_rd & id_rs1!=0) | (id_rs2_used & id_rs2==ex_rd & id_rs2!=0), qualified with ex_late_wr.
- dstall = dmem_req & !dmem_resp.
- istall = imem_req & !imem_resp.
- Defaults: stall=0, flush=0, pc_load=1.
- Priority, highest first: dstall, redirect, load-use, istall.
- dstall:
  - stall = all ones, flush = 0, pc_load = 0.
  - If redirect_valid, set redirect_pending next edge.
  - State and lu_cnt frozen.
- Redirect (redirect_valid, or redirect_pending with no dstall):
  - flush[1..RESOLVE_IDX] = 1.
  - If istall: pc_load = 0 and redirect_pending stays/sets.
  - Otherwise pc_load = 1 and redirect_pending clears.
  - In the cycle a pending redirect releases after istall (imem_resp=1), flush[1] = 1 to drop the wrong-path fetch.
  - Redirect aborts any load-use sequence: lu_cnt := 0, state := IDLE.
- Load-use:
  - In IDLE, hazard sets stall[0] = stall[1] = 1, flush[2] = 1, pc_load = 0.
  - If LU_BUBBLES>1, go to LU_WAIT with lu_cnt = LU_BUBBLES-1.
  - In LU_WAIT: same outputs each cycle, lu_cnt decrements; at lu_cnt==1 → IDLE.
  - LU_WAIT ignores the live hazard term; the producer has moved on.
- istall, no higher event:
  - stall[0] = stall[1] = 1, flush[2] = 1, pc_load = 0.
  - Registers 3.. advance.
- stall_cycles:
  - Increments when stall[0]=1; wraps modulo 2^CNT_W.
  - perf_clr has priority over the increment and zeroes the counter next edge.
- Never assert stall[i] and flush[i] together; flush wins only if the stall source is not dstall.
- Async reset mid-stall discards pending redirect and counters immediately.

Test Plan:
- Load-use, LU_BUBBLES=1: ex_rd=5, ex_late_wr=1, id_rs1=5, id_rs1_used=1 → one cycle stall=5'b00011, flush=5'b00100, pc_load=0; next cycle (hazard gone) all 0, pc_load=1.
- LU_BUBBLES=3: same hazard pulsed one cycle → exactly 3 consecutive cycles with stall[1:0]=2'b11, flush[2]=1; stall_cycles increases by 3.
- x0 and unused sources: id_rs1=0=ex_rd; separately id_rs2=7=ex_rd with id_rs2_used=0 → no stall, no flush.
- Redirect during dmem stall: dmem_req=1, dmem_resp=0 for 4 cycles, redirect_valid pulsed in cycle 2 → stall=5'b11111, flush=0 for 4 cycles, redirect_pending=1 from cycle 3. On dmem_resp: flush=5'b00110, pc_load=1, then redirect_pending=0.
- Redirect during imem miss: imem_req=1, imem_resp=0 for 3 cycles, redirect_valid in cycle 1 → flush[2:1] set, pc_load=0, pending=1. On imem_resp: pc_load=1, flush[1]=1, pending clears.
- Reset/counter: 10 stall cycles, then perf_clr → 0. Assert rst mid-LU_WAIT → outputs 0 and pending=0 without waiting for a clk edge.
